// File: rtl/ip_stream_pkg.sv
// rtl/ip_stream_pkg.sv - shared states, IPv4 field positions and word-0 checks
package ip_stream_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR  = 3'd1;
  localparam logic [2:0] ST_OPTS = 3'd2;
  localparam logic [2:0] ST_REQ  = 3'd3;
  localparam logic [2:0] ST_WAIT = 3'd4;
  localparam logic [2:0] ST_HOLD = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_HDR  = ST_HDR,
    S_OPTS = ST_OPTS,
    S_REQ  = ST_REQ,
    S_WAIT = ST_WAIT,
    S_HOLD = ST_HOLD
  } state_t;

  localparam logic [3:0] IPV4_VERSION = 4'd4;
  localparam logic [3:0] IHL_MIN      = 4'd5;
  localparam logic [3:0] SRC_WORD     = 4'd3;
  localparam logic [3:0] DST_WORD     = 4'd4;

  // word 0 layout: version in the top nibble, IHL in the next one
  localparam int VER_MSB = 31;
  localparam int VER_LSB = 28;
  localparam int IHL_MSB = 27;
  localparam int IHL_LSB = 24;

  function automatic logic [3:0] word0_ihl(input logic [31:0] w);
    return w[IHL_MSB:IHL_LSB];
  endfunction

  function automatic logic word0_ok(input logic [31:0] w);
    return (w[VER_MSB:VER_LSB] == IPV4_VERSION) && (w[IHL_MSB:IHL_LSB] >= IHL_MIN);
  endfunction

endpackage

// File: rtl/ip_header_extract_if.sv
// rtl/ip_header_extract_if.sv - header stream, address lookup and route handshake bundle
interface ip_header_extract_if;
  logic [31:0] word_in;
  logic        word_valid;
  logic        sop;
  logic        word_ready;
  logic [31:0] src;
  logic [31:0] dest;
  logic        ready;
  logic        done;
  logic        direct;
  logic        encrypt;
  logic        route_valid;
  logic        route_direct;
  logic        route_encrypt;
  logic        route_timeout;
  logic        route_ack;
  logic        hdr_err;

  // block side
  modport slave (
    input  word_in, word_valid, sop, done, direct, encrypt, route_ack,
    output word_ready, src, dest, ready, route_valid, route_direct,
           route_encrypt, route_timeout, hdr_err
  );

  // environment side: ingress buffer, address_check and AES selector
  modport master (
    output word_in, word_valid, sop, done, direct, encrypt, route_ack,
    input  word_ready, src, dest, ready, route_valid, route_direct,
           route_encrypt, route_timeout, hdr_err
  );
endinterface

// File: rtl/ip_hdr_word_counter.sv
// rtl/ip_hdr_word_counter.sv - header word index, stored IHL and last-word flag
module ip_hdr_word_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       step,
  input  logic [3:0] ihl_in,
  output logic [3:0] wcnt,
  output logic [3:0] ihl,
  output logic       last
);

  // wcnt is the index of the next word to arrive; word 0 already seen on start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt <= 4'd0;
      ihl  <= 4'd0;
    end else if (start) begin
      wcnt <= 4'd1;
      ihl  <= ihl_in;
    end else if (step) begin
      wcnt <= wcnt + 4'd1;
    end
  end

  // high while the word now arriving is the final header word
  assign last = (wcnt == (ihl - 4'd1));

endmodule

// File: rtl/ip_header_extract.sv
// rtl/ip_header_extract.sv - IPv4 header parser and address lookup initiator
module ip_header_extract
  import ip_stream_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic                clk,
  input  logic                reset,
  ip_header_extract_if.slave  bus
);

  // ready stays up for REQ plus WAIT cycles 0..TIMEOUT_CYCLES-2, i.e. TIMEOUT_CYCLES cycles
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  state_t           state_q, state_d;
  logic [3:0]       wcnt, ihl;
  logic             last;
  logic [CNT_W-1:0] tmo_cnt;
  logic             word_ready_q, ready_q, route_valid_q, hdr_err_q;
  logic             route_direct_q, route_encrypt_q, route_timeout_q;
  logic [31:0]      src_q, dest_q;
  logic             xfer, w0_ok;
  logic             cnt_start, cnt_step, err_d, ld_src, ld_dst;
  logic             tmo_clr, tmo_inc, lat_done, lat_tmo;

  assign xfer  = bus.word_valid & word_ready_q;
  assign w0_ok = word0_ok(bus.word_in);

  ip_hdr_word_counter u_cnt (
    .clk    (clk),
    .reset  (reset),
    .start  (cnt_start),
    .step   (cnt_step),
    .ihl_in (word0_ihl(bus.word_in)),
    .wcnt   (wcnt),
    .ihl    (ihl),
    .last   (last)
  );

  // next state and per-cycle strobes
  always_comb begin
    state_d   = state_q;
    cnt_start = 1'b0;
    cnt_step  = 1'b0;
    err_d     = 1'b0;
    ld_src    = 1'b0;
    ld_dst    = 1'b0;
    tmo_clr   = 1'b0;
    tmo_inc   = 1'b0;
    lat_done  = 1'b0;
    lat_tmo   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (xfer && bus.sop) begin
          if (w0_ok) begin
            cnt_start = 1'b1;
            state_d   = S_HDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_HDR, S_OPTS: begin
        if (xfer && bus.sop) begin
          // restart: the aborting word is itself a candidate word 0
          err_d = 1'b1;
          if (w0_ok) begin
            cnt_start = 1'b1;
            state_d   = S_HDR;
          end else begin
            state_d = S_IDLE;
          end
        end else if (xfer) begin
          cnt_step = 1'b1;
          if (state_q == S_HDR) begin
            ld_src = (wcnt == SRC_WORD);
            ld_dst = (wcnt == DST_WORD);
            if (wcnt == DST_WORD) state_d = last ? S_REQ : S_OPTS;
          end else if (last) begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        tmo_clr = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.done) begin
          lat_done = 1'b1;
          state_d  = S_HOLD;
        end else if (tmo_cnt == TMO_LAST) begin
          lat_tmo = 1'b1;
          state_d = S_HOLD;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      S_HOLD: begin
        if (bus.route_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state, registered outputs, captured addresses and lookup result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      word_ready_q    <= 1'b0;
      ready_q         <= 1'b0;
      route_valid_q   <= 1'b0;
      hdr_err_q       <= 1'b0;
      route_direct_q  <= 1'b0;
      route_encrypt_q <= 1'b0;
      route_timeout_q <= 1'b0;
      src_q           <= 32'd0;
      dest_q          <= 32'd0;
      tmo_cnt         <= '0;
    end else begin
      state_q       <= state_d;
      word_ready_q  <= (state_d == S_IDLE) || (state_d == S_HDR) || (state_d == S_OPTS);
      ready_q       <= (state_d == S_REQ) || (state_d == S_WAIT);
      route_valid_q <= (state_d == S_HOLD);
      hdr_err_q     <= err_d;
      if (ld_src) src_q  <= bus.word_in;
      if (ld_dst) dest_q <= bus.word_in;
      if (tmo_clr)      tmo_cnt <= '0;
      else if (tmo_inc) tmo_cnt <= tmo_cnt + 1'b1;
      if (lat_done) begin
        route_direct_q  <= bus.direct;
        route_encrypt_q <= bus.encrypt;
        route_timeout_q <= 1'b0;
      end else if (lat_tmo) begin
        route_direct_q  <= 1'b1;
        route_encrypt_q <= 1'b0;
        route_timeout_q <= 1'b1;
      end
    end
  end

  assign bus.word_ready    = word_ready_q;
  assign bus.ready         = ready_q;
  assign bus.route_valid   = route_valid_q;
  assign bus.hdr_err       = hdr_err_q;
  assign bus.route_direct  = route_direct_q;
  assign bus.route_encrypt = route_encrypt_q;
  assign bus.route_timeout = route_timeout_q;
  assign bus.src           = src_q;
  assign bus.dest          = dest_q;

endmodule

// File: tb/tb_ip_header_extract.sv
// tb/tb_ip_header_extract.sv - directed scoreboard bench for ip_header_extract
module tb_ip_header_extract;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic        d;
    logic        e;
    logic        t;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   err_cnt = 0;
  int   rdy_cnt = 0;
  exp_t sb[$];

  ip_header_extract_if bus ();

  ip_header_extract #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // mid-cycle monitors of pulse and request activity
  always @(negedge clk) begin
    if (bus.hdr_err === 1'b1) err_cnt++;
    if (bus.ready === 1'b1) rdy_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input logic s);
    int guard = 0;
    bus.word_in    = w;
    bus.word_valid = 1'b1;
    bus.sop        = s;
    while (bus.word_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) chk("word_ready_wait", {31'd0, bus.word_ready}, 32'd1);
    @(negedge clk);
    bus.word_valid = 1'b0;
    bus.sop        = 1'b0;
  endtask

  task automatic send_hdr5(input logic [31:0] w0, input logic [31:0] s, input logic [31:0] d);
    send_word(w0, 1'b1);
    send_word(32'h0, 1'b0);
    send_word(32'h40060000, 1'b0);
    send_word(s, 1'b0);
    send_word(d, 1'b0);
  endtask

  // address_check model plus route consumer; done (if any) arrives on the 2nd ready cycle
  task automatic lookup(input string tag, input logic give_done, input logic d, input logic e,
                        input int exp_hi);
    int   hi = 0;
    int   guard = 0;
    exp_t x;
    chk({tag, "_ready_up"}, {31'd0, bus.ready}, 32'd1);
    chk({tag, "_wr_low"}, {31'd0, bus.word_ready}, 32'd0);
    while (bus.ready === 1'b1 && guard < 40) begin
      hi++;
      if (give_done && hi == 2) begin
        bus.done    = 1'b1;
        bus.direct  = d;
        bus.encrypt = e;
      end
      @(negedge clk);
      guard++;
    end
    bus.done = 1'b0;
    chk({tag, "_ready_cycles"}, hi, exp_hi);
    chk({tag, "_route_valid"}, {31'd0, bus.route_valid}, 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      x = sb.pop_front();
      chk({tag, "_src"}, bus.src, x.src);
      chk({tag, "_dest"}, bus.dest, x.dst);
      chk({tag, "_route"}, {29'd0, bus.route_direct, bus.route_encrypt, bus.route_timeout},
          {29'd0, x.d, x.e, x.t});
    end
    @(negedge clk);
    chk({tag, "_route_hold"}, {31'd0, bus.route_valid}, 32'd1);
    bus.route_ack = 1'b1;
    @(negedge clk);
    bus.route_ack = 1'b0;
    chk({tag, "_route_drop"}, {31'd0, bus.route_valid}, 32'd0);
    chk({tag, "_wr_back"}, {31'd0, bus.word_ready}, 32'd1);
  endtask

  initial begin
    int e0, r0;
    bus.word_in = 32'h0; bus.word_valid = 1'b0; bus.sop = 1'b0;
    bus.done = 1'b0; bus.direct = 1'b0; bus.encrypt = 1'b0; bus.route_ack = 1'b0;

    // reset state
    @(negedge clk); @(negedge clk);
    chk("rst_outs", {25'd0, bus.word_ready, bus.ready, bus.route_valid, bus.route_direct,
                     bus.route_encrypt, bus.route_timeout, bus.hdr_err}, 32'd0);
    chk("rst_src", bus.src, 32'd0);
    chk("rst_dest", bus.dest, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // basic packet
    sb.push_back('{32'hC0A80001, 32'h0A000005, 1'b0, 1'b1, 1'b0});
    send_hdr5(32'h45000054, 32'hC0A80001, 32'h0A000005);
    lookup("basic", 1'b1, 1'b0, 1'b1, 2);

    // options: IHL 7, ready only after the 7th word
    sb.push_back('{32'h0A010203, 32'h0A040506, 1'b1, 1'b0, 1'b0});
    send_word(32'h47000060, 1'b1);
    send_word(32'h0, 1'b0);
    send_word(32'h40110000, 1'b0);
    send_word(32'h0A010203, 1'b0);
    send_word(32'h0A040506, 1'b0);
    send_word(32'hDEADBEEF, 1'b0);
    chk("opts_no_ready", {31'd0, bus.ready}, 32'd0);
    send_word(32'hCAFEF00D, 1'b0);
    lookup("opts", 1'b1, 1'b1, 1'b0, 2);

    // bad headers: version 6, then IHL 4
    e0 = err_cnt; r0 = rdy_cnt;
    send_word(32'h65000000, 1'b1);
    send_word(32'h12345678, 1'b0);
    send_word(32'h44000000, 1'b1);
    send_word(32'h9ABCDEF0, 1'b0);
    @(negedge clk); @(negedge clk);
    chk("bad_err_pulses", err_cnt - e0, 32'd2);
    chk("bad_no_ready", rdy_cnt - r0, 32'd0);
    chk("bad_wr", {31'd0, bus.word_ready}, 32'd1);

    // timeout: no done ever
    sb.push_back('{32'h01020304, 32'h05060708, 1'b1, 1'b0, 1'b1});
    send_hdr5(32'h45000054, 32'h01020304, 32'h05060708);
    lookup("tmo", 1'b0, 1'b0, 1'b0, 16);

    // restart on word 2
    e0 = err_cnt;
    sb.push_back('{32'hAC100001, 32'hAC100002, 1'b0, 1'b0, 1'b0});
    send_word(32'h45000028, 1'b1);
    send_word(32'h00000001, 1'b0);
    send_hdr5(32'h45000030, 32'hAC100001, 32'hAC100002);
    chk("restart_err", err_cnt - e0, 32'd1);
    lookup("restart", 1'b1, 1'b0, 1'b0, 2);

    // async reset while waiting on the lookup
    send_hdr5(32'h45000054, 32'h11111111, 32'h22222222);
    chk("ar_ready_up", {31'd0, bus.ready}, 32'd1);
    @(negedge clk); @(negedge clk); @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("ar_outs", {29'd0, bus.ready, bus.route_valid, bus.word_ready}, 32'd0);
    chk("ar_src", bus.src, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    sb.push_back('{32'hC0A80001, 32'h0A000005, 1'b1, 1'b1, 1'b0});
    send_hdr5(32'h45000054, 32'hC0A80001, 32'h0A000005);
    lookup("post_rst", 1'b1, 1'b1, 1'b1, 2);
    chk("sb_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
